// File: rtl/spi_pkg.sv
// Register map, status bit positions and status packing shared by the SPI
// master and slave cores.
package spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int unsigned ST_ROE  = 3;
  localparam int unsigned ST_TOE  = 4;
  localparam int unsigned ST_TUR  = 5;
  localparam int unsigned ST_TRDY = 6;
  localparam int unsigned ST_RRDY = 7;
  localparam int unsigned ST_E    = 8;

  typedef struct packed {
    logic rrdy;
    logic trdy;
    logic tur;
    logic toe;
    logic roe;
  } spi_flags_t;

  function automatic logic [15:0] pack_status(input spi_flags_t f);
    logic [15:0] s;
    s          = '0;
    s[ST_E]    = f.roe | f.toe | f.tur;
    s[ST_RRDY] = f.rrdy;
    s[ST_TRDY] = f.trdy;
    s[ST_TUR]  = f.tur;
    s[ST_TOE]  = f.toe;
    s[ST_ROE]  = f.roe;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_port_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input with single-clk
// rise/fall pulses derived from one extra history flop.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with an oversampled serial side and
// a CPU register port: rx data, tx data, status, control.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int unsigned     CNT_W    = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .d_i(SCLK),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .d_i(SS_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .d_i(MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall));

  logic                  sel;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, next_q, next_d;
  logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  rx_bit_q, rx_bit_d, pend_q, pend_d;
  logic                  trdy_q, trdy_d, rrdy_q, rrdy_d;
  logic                  roe_q, roe_d, toe_q, toe_d, tur_q, tur_d;
  logic [8:3]            ctrl_q, ctrl_d;
  logic [15:0]           dout_q, dout_d, status;
  logic                  irq_q, irq_d, rd_acc_q, wr_acc_q;
  logic                  rd_stb, wr_stb, word_done, preload, consume, trdy_eff;
  logic                  unused_cpu_bits;
  spi_flags_t            flags;

  assign sel       = ~ss_lvl;
  assign rd_stb    = spi_select & ~read_n & ~rd_acc_q;
  assign wr_stb    = spi_select & ~write_n & ~wr_acc_q;
  assign word_done = sel & sclk_rise & ~ss_fall & (bit_cnt_q == LAST_BIT);
  assign preload   = ss_fall | word_done;
  // A preload drains tx_hold before any same-clk CPU write is judged.
  assign consume   = preload & ~trdy_q;
  assign trdy_eff  = trdy_q | consume;
  assign flags     = '{rrdy: rrdy_q, trdy: trdy_q, tur: tur_q, toe: toe_q, roe: roe_q};
  assign status    = pack_status(flags);
  assign unused_cpu_bits = ^data_from_cpu;

  always_comb begin
    shift_d   = shift_q;
    next_d    = next_q;
    rx_hold_d = rx_hold_q;
    tx_hold_d = tx_hold_q;
    bit_cnt_d = bit_cnt_q;
    rx_bit_d  = rx_bit_q;
    pend_d    = pend_q;
    trdy_d    = trdy_eff;
    rrdy_d    = rrdy_q;
    roe_d     = roe_q;
    toe_d     = toe_q;
    tur_d     = tur_q;
    ctrl_d    = ctrl_q;
    dout_d    = dout_q;
    irq_d     = |(status[8:3] & ctrl_q);

    if (ss_fall) begin
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      shift_d   = consume ? tx_hold_q : '0;
    end else if (ss_rise) begin
      bit_cnt_d = '0;
      pend_d    = 1'b0;
    end else if (sel) begin
      if (sclk_rise) begin
        rx_bit_d = mosi_lvl;
        if (word_done) begin
          bit_cnt_d = '0;
          rx_hold_d = DATA_WIDTH'({shift_q, mosi_lvl});
          next_d    = consume ? tx_hold_q : '0;
          pend_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      // The word boundary's falling edge loads the next word instead of shifting.
      if (sclk_fall) begin
        shift_d = pend_q ? next_q : DATA_WIDTH'({shift_q, rx_bit_q});
        pend_d  = 1'b0;
      end
    end

    if (wr_stb) begin
      case (mem_addr)
        ADDR_TXDATA: begin
          if (trdy_eff) begin
            tx_hold_d = data_from_cpu[DATA_WIDTH-1:0];
            trdy_d    = 1'b0;
          end else begin
            toe_d = 1'b1;
          end
        end
        ADDR_STATUS: begin
          rrdy_d = 1'b0;
          roe_d  = 1'b0;
          toe_d  = 1'b0;
          tur_d  = 1'b0;
        end
        ADDR_CONTROL: ctrl_d = data_from_cpu[8:3];
        default: ;
      endcase
    end

    if (rd_stb) begin
      case (mem_addr)
        ADDR_RXDATA: begin
          dout_d = 16'(rx_hold_q);
          rrdy_d = 1'b0;
        end
        ADDR_STATUS:  dout_d = status;
        ADDR_CONTROL: dout_d = {7'b0, ctrl_q, 3'b0};
        default:      dout_d = '0;
      endcase
    end

    if (word_done) begin
      rrdy_d = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
    end
    if (preload & trdy_q) tur_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      next_q    <= '0;
      rx_hold_q <= '0;
      tx_hold_q <= '0;
      bit_cnt_q <= '0;
      rx_bit_q  <= 1'b0;
      pend_q    <= 1'b0;
      trdy_q    <= 1'b1;
      rrdy_q    <= 1'b0;
      roe_q     <= 1'b0;
      toe_q     <= 1'b0;
      tur_q     <= 1'b0;
      ctrl_q    <= '0;
      dout_q    <= '0;
      irq_q     <= 1'b0;
      rd_acc_q  <= 1'b0;
      wr_acc_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      next_q    <= next_d;
      rx_hold_q <= rx_hold_d;
      tx_hold_q <= tx_hold_d;
      bit_cnt_q <= bit_cnt_d;
      rx_bit_q  <= rx_bit_d;
      pend_q    <= pend_d;
      trdy_q    <= trdy_d;
      rrdy_q    <= rrdy_d;
      roe_q     <= roe_d;
      toe_q     <= toe_d;
      tur_q     <= tur_d;
      ctrl_q    <= ctrl_d;
      dout_q    <= dout_d;
      irq_q     <= irq_d;
      rd_acc_q  <= spi_select & ~read_n;
      wr_acc_q  <= spi_select & ~write_n;
    end
  end

  assign MISO          = sel ? shift_q[DATA_WIDTH-1] : 1'b1;
  assign MISO_oe       = sel;
  assign data_to_cpu   = dout_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a behavioural SPI master at clk/10 plus
// CPU register accesses, checked against hand-computed values.
module tb_spi_slave_port;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
  logic        spi_select, read_n, write_n, irq, dataavailable, readyfordata;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
    .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half();
    cycles(5);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask

  task automatic bit_xfer(input logic b, output logic m);
    MOSI = b;
    half();
    SCLK = 1'b1;
    m = MISO;
    half();
    SCLK = 1'b0;
  endtask

  task automatic xfer_word(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic m;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bit_xfer(tx[7-i], m);
      rx[7-i] = m;
    end
  endtask

  task automatic frame_begin();
    SS_n = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    SS_n = 1'b1;
    half();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rxb;
    logic [15:0] rd;
    logic        m;
    reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
    mem_addr = '0; data_from_cpu = '0;
    cycles(4);
    chk("rst_miso", MISO, 1'b1);
    chk("rst_oe", MISO_oe, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rrdy", dataavailable, 1'b0);
    chk("rst_trdy", readyfordata, 1'b1);
    chk("rst_dout", data_to_cpu, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    cycles(3);
    cpu_read(ADDR_STATUS, rd);
    chk("rst_status", rd, 16'h0040);

    // Preloaded 0xA5 out, 0x3C in, RRDY interrupt enabled
    cpu_write(ADDR_CONTROL, 16'h0080);
    cpu_write(ADDR_TXDATA, 16'h00A5);
    chk("t1_trdy_loaded", readyfordata, 1'b0);
    frame_begin();
    chk("t1_trdy_start", readyfordata, 1'b1);
    chk("t1_oe_sel", MISO_oe, 1'b1);
    xfer_word(8'h3C, 8, rxb);
    chk("t1_miso_word", rxb, 8'hA5);
    cycles(3);
    chk("t1_rrdy", dataavailable, 1'b1);
    chk("t1_irq", irq, 1'b1);
    frame_end();
    chk("t1_oe_desel", MISO_oe, 1'b0);
    chk("t1_miso_idle", MISO, 1'b1);
    cpu_read(ADDR_CONTROL, rd);
    chk("t1_ctrl", rd, 16'h0080);
    cpu_read(ADDR_RXDATA, rd);
    chk("t1_rx", rd, 16'h003C);
    cpu_read(ADDR_STATUS, rd);
    chk("t1_status", rd, 16'h0160);
    chk("t1_irq_clr", irq, 1'b0);
    cpu_write(ADDR_STATUS, 16'h0000);

    // Overrun: 0x11 then 0x22 without a read; no tx preload
    frame_begin();
    xfer_word(8'h11, 8, rxb);
    chk("t2_miso_underrun", rxb, 8'h00);
    frame_end();
    frame_begin();
    xfer_word(8'h22, 8, rxb);
    frame_end();
    cpu_read(ADDR_STATUS, rd);
    chk("t2_status_ovr", rd, 16'h01E8);
    cpu_read(ADDR_RXDATA, rd);
    chk("t2_rx_last", rd, 16'h0022);
    cpu_write(ADDR_STATUS, 16'hFFFF);
    cpu_read(ADDR_STATUS, rd);
    chk("t2_status_clr", rd, 16'h0040);

    // Tx overrun: second write dropped, first value transmitted
    cpu_write(ADDR_TXDATA, 16'h005A);
    cpu_write(ADDR_TXDATA, 16'h0077);
    cpu_read(ADDR_STATUS, rd);
    chk("t3_status_toe", rd, 16'h0110);
    frame_begin();
    xfer_word(8'h00, 8, rxb);
    chk("t3_miso_first", rxb, 8'h5A);
    frame_end();
    cpu_read(ADDR_RXDATA, rd);
    chk("t3_rx", rd, 16'h0000);
    cpu_write(ADDR_STATUS, 16'h0000);

    // Aborted 5-bit frame, then full 0x81
    frame_begin();
    xfer_word(8'hFF, 5, rxb);
    frame_end();
    chk("t4_no_rrdy", dataavailable, 1'b0);
    chk("t4_oe_gap", MISO_oe, 1'b0);
    chk("t4_miso_gap", MISO, 1'b1);
    frame_begin();
    xfer_word(8'h81, 8, rxb);
    frame_end();
    chk("t4_rrdy", dataavailable, 1'b1);
    cpu_read(ADDR_RXDATA, rd);
    chk("t4_rx", rd, 16'h0081);
    cpu_write(ADDR_STATUS, 16'h0000);

    // Back-to-back words, tx refilled mid first word
    cpu_write(ADDR_TXDATA, 16'h0012);
    frame_begin();
    rxb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) cpu_write(ADDR_TXDATA, 16'h0034);
      bit_xfer(logic'(8'hC3 >> (7 - i)), m);
      rxb[7-i] = m;
    end
    chk("t5_miso_w1", rxb, 8'h12);
    cpu_read(ADDR_RXDATA, rd);
    chk("t5_rx_w1", rd, 16'h00C3);
    xfer_word(8'h5E, 8, rxb);
    chk("t5_miso_w2", rxb, 8'h34);
    frame_end();
    cpu_read(ADDR_RXDATA, rd);
    chk("t5_rx_w2", rd, 16'h005E);
    cpu_read(ADDR_STATUS, rd);
    chk("t5_status", rd, 16'h0160);
    cpu_write(ADDR_STATUS, 16'h0000);

    // Reset at bit 4 aborts everything
    cpu_write(ADDR_TXDATA, 16'h00F0);
    frame_begin();
    xfer_word(8'hAA, 4, rxb);
    @(negedge clk);
    reset_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0;
    cycles(2);
    chk("t6_miso_rst", MISO, 1'b1);
    chk("t6_oe_rst", MISO_oe, 1'b0);
    chk("t6_trdy_rst", readyfordata, 1'b1);
    chk("t6_rrdy_rst", dataavailable, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    cycles(3);
    cpu_read(ADDR_STATUS, rd);
    chk("t6_status", rd, 16'h0040);
    cpu_read(ADDR_CONTROL, rd);
    chk("t6_ctrl", rd, 16'h0000);
    frame_begin();
    xfer_word(8'h6D, 8, rxb);
    chk("t6_miso", rxb, 8'h00);
    frame_end();
    chk("t6_rrdy", dataavailable, 1'b1);
    chk("t6_irq_masked", irq, 1'b0);
    cpu_read(ADDR_RXDATA, rd);
    chk("t6_rx", rd, 16'h006D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
